// File: rtl/writeback_arbiter.sv
// writeback_arbiter
// Merges the single-cycle ALU result path and the multi-cycle load path onto
// the single write port of the register file. Each source owns a one-entry
// holding register behind a valid/ready handshake; a fixed-priority arbiter
// (memory first) picks at most one entry per cycle and loads a registered
// output stage that drives write_reg / write_data / reg_write.
//
// Handshake: a transfer happens on a rising edge where X_valid & X_ready.
// X_ready = ~X_full | X_drain and depends only on state, never on X_valid.
// A transfer whose destination is x0 completes but is dropped.
//
// Optional feature macro: WB_STARVE_GUARD_EN. When defined, a 4-bit counter
// tracks consecutive lost arbitrations of the ALU entry; once it reaches
// STARVE_LIMIT (legal 1..15) the ALU entry wins the next arbitration.
// When undefined, memory has strict priority and the ALU may wait forever.
module writeback_arbiter #(
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  alu_valid,
    input  logic [4:0]            alu_rd,
    input  logic [DATA_WIDTH-1:0] alu_data,
    output logic                  alu_ready,
    input  logic                  mem_valid,
    input  logic [4:0]            mem_rd,
    input  logic [DATA_WIDTH-1:0] mem_data,
    output logic                  mem_ready,
    output logic [4:0]            write_reg,
    output logic [DATA_WIDTH-1:0] write_data,
    output logic                  reg_write,
    output logic                  busy
);

    // Holding registers
    logic                  alu_full_q, alu_full_d;
    logic [4:0]            alu_rd_q, alu_rd_d;
    logic [DATA_WIDTH-1:0] alu_data_q, alu_data_d;
    logic                  mem_full_q, mem_full_d;
    logic [4:0]            mem_rd_q, mem_rd_d;
    logic [DATA_WIDTH-1:0] mem_data_q, mem_data_d;

    // Output stage
    logic                  reg_write_q, reg_write_d;
    logic [4:0]            write_reg_q, write_reg_d;
    logic [DATA_WIDTH-1:0] write_data_q, write_data_d;

    // Arbitration results
    logic alu_drain;
    logic mem_drain;
    logic force_alu;
    logic alu_take;
    logic mem_take;

`ifdef WB_STARVE_GUARD_EN
    localparam logic [3:0] LIMIT = STARVE_LIMIT[3:0];

    logic [3:0] starve_q, starve_d;

    // ALU entry is forced through once it has lost LIMIT arbitrations in a row
    assign force_alu = (starve_q == LIMIT);

    // Count cycles where the ALU entry waits; a win clears the count
    always_comb begin
        starve_d = starve_q;
        if (alu_drain) begin
            starve_d = 4'd0;
        end else if (alu_full_q) begin
            starve_d = starve_q + 4'd1;
        end
    end

    // Starvation counter register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve_q <= 4'd0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    assign force_alu = 1'b0;
`endif

    // Fixed priority: memory wins unless the ALU is alone or being forced
    always_comb begin
        alu_drain = alu_full_q & (~mem_full_q | force_alu);
        mem_drain = mem_full_q & ~alu_drain;
    end

    // Ready is a pure function of state so it never loops back through valid
    assign alu_ready = ~alu_full_q | alu_drain;
    assign mem_ready = ~mem_full_q | mem_drain;

    // Only non-x0 transfers occupy a holding register
    assign alu_take = alu_valid & alu_ready & (alu_rd != 5'd0);
    assign mem_take = mem_valid & mem_ready & (mem_rd != 5'd0);

    // Next state of both holds: drain empties, a same-edge capture refills
    always_comb begin
        alu_full_d = alu_full_q & ~alu_drain;
        alu_rd_d   = alu_rd_q;
        alu_data_d = alu_data_q;
        mem_full_d = mem_full_q & ~mem_drain;
        mem_rd_d   = mem_rd_q;
        mem_data_d = mem_data_q;
        if (alu_take) begin
            alu_full_d = 1'b1;
            alu_rd_d   = alu_rd;
            alu_data_d = alu_data;
        end
        if (mem_take) begin
            mem_full_d = 1'b1;
            mem_rd_d   = mem_rd;
            mem_data_d = mem_data;
        end
    end

    // Holding register state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            alu_full_q <= 1'b0;
            alu_rd_q   <= 5'd0;
            alu_data_q <= '0;
            mem_full_q <= 1'b0;
            mem_rd_q   <= 5'd0;
            mem_data_q <= '0;
        end else begin
            alu_full_q <= alu_full_d;
            alu_rd_q   <= alu_rd_d;
            alu_data_q <= alu_data_d;
            mem_full_q <= mem_full_d;
            mem_rd_q   <= mem_rd_d;
            mem_data_q <= mem_data_d;
        end
    end

    // Winner loads the write port; with no winner the address/data are kept
    always_comb begin
        reg_write_d  = alu_drain | mem_drain;
        write_reg_d  = write_reg_q;
        write_data_d = write_data_q;
        if (mem_drain) begin
            write_reg_d  = mem_rd_q;
            write_data_d = mem_data_q;
        end else if (alu_drain) begin
            write_reg_d  = alu_rd_q;
            write_data_d = alu_data_q;
        end
    end

    // Registered write port toward the register file
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            reg_write_q  <= 1'b0;
            write_reg_q  <= 5'd0;
            write_data_q <= '0;
        end else begin
            reg_write_q  <= reg_write_d;
            write_reg_q  <= write_reg_d;
            write_data_q <= write_data_d;
        end
    end

    assign reg_write  = reg_write_q;
    assign write_reg  = write_reg_q;
    assign write_data = write_data_q;
    assign busy       = alu_full_q | mem_full_q | reg_write_q;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter. A small register-file model commits
// on every rising edge where reg_write is high, so read-back expectations
// follow the real downstream timing. Build with +define+WB_STARVE_GUARD_EN
// to exercise the starvation guard expectations.
module tb_writeback_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        alu_ready;
    logic        mem_valid;
    logic [4:0]  mem_rd;
    logic [31:0] mem_data;
    logic        mem_ready;
    logic [4:0]  write_reg;
    logic [31:0] write_data;
    logic        reg_write;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    // Register file model and commit counter
    logic [31:0] rf [32] = '{default: '0};
    int          commits = 0;

    writeback_arbiter #(
        .DATA_WIDTH   (32),
        .STARVE_LIMIT (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .alu_valid  (alu_valid),
        .alu_rd     (alu_rd),
        .alu_data   (alu_data),
        .alu_ready  (alu_ready),
        .mem_valid  (mem_valid),
        .mem_rd     (mem_rd),
        .mem_data   (mem_data),
        .mem_ready  (mem_ready),
        .write_reg  (write_reg),
        .write_data (write_data),
        .reg_write  (reg_write),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (reg_write) begin
            commits <= commits + 1;
            if (write_reg != 5'd0) rf[write_reg] <= write_data;
        end
    end

    // One clock: advance through a rising edge and settle at the next falling edge
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        alu_valid = 1'b0; alu_rd = 5'd0; alu_data = 32'h0;
        mem_valid = 1'b0; mem_rd = 5'd0; mem_data = 32'h0;
        repeat (2) @(negedge clk);
        n_checks++; if (reg_write !== 1'b0) begin n_fail++; $display("FAIL reset_reg_write got=%b exp=0", reg_write); end
        n_checks++; if (write_reg !== 5'd0) begin n_fail++; $display("FAIL reset_write_reg got=%0d exp=0", write_reg); end
        n_checks++; if (write_data !== 32'h0) begin n_fail++; $display("FAIL reset_write_data got=%h exp=0", write_data); end
        n_checks++; if (alu_ready !== 1'b1) begin n_fail++; $display("FAIL reset_alu_ready got=%b exp=1", alu_ready); end
        n_checks++; if (mem_ready !== 1'b1) begin n_fail++; $display("FAIL reset_mem_ready got=%b exp=1", mem_ready); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_alu_single();
        alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'haaaabbbb;
        n_checks++; if (alu_ready !== 1'b1) begin n_fail++; $display("FAIL single_alu_ready got=%b exp=1", alu_ready); end
        step();
        alu_valid = 1'b0;
        n_checks++; if (reg_write !== 1'b0) begin n_fail++; $display("FAIL single_latency got=%b exp=0", reg_write); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_held got=%b exp=1", busy); end
        step();
        n_checks++; if (reg_write !== 1'b1) begin n_fail++; $display("FAIL single_reg_write got=%b exp=1", reg_write); end
        n_checks++; if (write_reg !== 5'd1) begin n_fail++; $display("FAIL single_write_reg got=%0d exp=1", write_reg); end
        n_checks++; if (write_data !== 32'haaaabbbb) begin n_fail++; $display("FAIL single_write_data got=%h exp=aaaabbbb", write_data); end
        step();
        n_checks++; if (reg_write !== 1'b0) begin n_fail++; $display("FAIL single_pulse_width got=%b exp=0", reg_write); end
        n_checks++; if (rf[1] !== 32'haaaabbbb) begin n_fail++; $display("FAIL single_readback got=%h exp=aaaabbbb", rf[1]); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_idle got=%b exp=0", busy); end
    endtask

    task automatic test_x0_filter();
        int c0;
        c0 = commits;
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hffffffff;
        n_checks++; if (alu_ready !== 1'b1) begin n_fail++; $display("FAIL x0_alu_ready got=%b exp=1", alu_ready); end
        step();
        alu_valid = 1'b0;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL x0_not_held got=%b exp=0", busy); end
        step();
        n_checks++; if (reg_write !== 1'b0) begin n_fail++; $display("FAIL x0_reg_write got=%b exp=0", reg_write); end
        step();
        n_checks++; if (commits !== c0) begin n_fail++; $display("FAIL x0_no_commit got=%0d exp=%0d", commits, c0); end
    endtask

    task automatic test_simultaneous();
        alu_valid = 1'b1; alu_rd = 5'd2; alu_data = 32'h11111111;
        mem_valid = 1'b1; mem_rd = 5'd3; mem_data = 32'h22222222;
        step();
        alu_valid = 1'b0; mem_valid = 1'b0;
        n_checks++; if (alu_ready !== 1'b0) begin n_fail++; $display("FAIL sim_alu_ready got=%b exp=0", alu_ready); end
        n_checks++; if (mem_ready !== 1'b1) begin n_fail++; $display("FAIL sim_mem_ready got=%b exp=1", mem_ready); end
        n_checks++; if (reg_write !== 1'b0) begin n_fail++; $display("FAIL sim_latency got=%b exp=0", reg_write); end
        step();
        n_checks++; if (reg_write !== 1'b1) begin n_fail++; $display("FAIL sim_first_we got=%b exp=1", reg_write); end
        n_checks++; if (write_reg !== 5'd3) begin n_fail++; $display("FAIL sim_first_reg got=%0d exp=3", write_reg); end
        n_checks++; if (write_data !== 32'h22222222) begin n_fail++; $display("FAIL sim_first_data got=%h exp=22222222", write_data); end
        step();
        n_checks++; if (reg_write !== 1'b1) begin n_fail++; $display("FAIL sim_second_we got=%b exp=1", reg_write); end
        n_checks++; if (write_reg !== 5'd2) begin n_fail++; $display("FAIL sim_second_reg got=%0d exp=2", write_reg); end
        n_checks++; if (write_data !== 32'h11111111) begin n_fail++; $display("FAIL sim_second_data got=%h exp=11111111", write_data); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL sim_busy_during got=%b exp=1", busy); end
        step();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL sim_busy_after got=%b exp=0", busy); end
        n_checks++; if (rf[3] !== 32'h22222222) begin n_fail++; $display("FAIL sim_x3 got=%h exp=22222222", rf[3]); end
        n_checks++; if (rf[2] !== 32'h11111111) begin n_fail++; $display("FAIL sim_x2 got=%h exp=11111111", rf[2]); end
    endtask

    task automatic test_same_rd();
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h1;
        mem_valid = 1'b1; mem_rd = 5'd5; mem_data = 32'h2;
        step();
        alu_valid = 1'b0; mem_valid = 1'b0;
        repeat (3) step();
        n_checks++; if (rf[5] !== 32'h1) begin n_fail++; $display("FAIL same_rd_x5 got=%h exp=1", rf[5]); end
    endtask

    task automatic test_starvation();
        int   first_alu_k;
        int   mem_wr_before;
        logic ar1;
        logic mr5;
        int   exp_first;
        int   exp_mem_wr;
        logic exp_mr5;
        first_alu_k   = -1;
        mem_wr_before = 0;
        ar1           = 1'bx;
        mr5           = 1'bx;
        alu_valid = 1'b1; alu_rd = 5'd7;  alu_data = 32'hdeadbeef;
        mem_valid = 1'b1; mem_rd = 5'd10; mem_data = 32'h00001000;
        @(posedge clk);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            alu_valid = 1'b0;
            if (reg_write && first_alu_k < 0) begin
                if (write_reg == 5'd7) first_alu_k = k;
                else if (write_reg == 5'd10) mem_wr_before++;
            end
            if (k == 1) ar1 = alu_ready;
            if (k == 5) mr5 = mem_ready;
            @(posedge clk);
        end
        @(negedge clk);
        mem_valid = 1'b0;
`ifdef WB_STARVE_GUARD_EN
        exp_first  = 6;
        exp_mem_wr = 4;
        exp_mr5    = 1'b0;
`else
        exp_first  = -1;
        exp_mem_wr = 11;
        exp_mr5    = 1'b1;
`endif
        n_checks++; if (ar1 !== 1'b0) begin n_fail++; $display("FAIL starve_alu_blocked got=%b exp=0", ar1); end
        n_checks++; if (first_alu_k !== exp_first) begin n_fail++; $display("FAIL starve_alu_write_cycle got=%0d exp=%0d", first_alu_k, exp_first); end
        n_checks++; if (mem_wr_before !== exp_mem_wr) begin n_fail++; $display("FAIL starve_lost_cycles got=%0d exp=%0d", mem_wr_before, exp_mem_wr); end
        n_checks++; if (mr5 !== exp_mr5) begin n_fail++; $display("FAIL starve_mem_ready got=%b exp=%b", mr5, exp_mr5); end
        for (int i = 0; i < 10; i++) begin
            if (!busy) break;
            step();
        end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL starve_drain_timeout got=%b exp=0", busy); end
        n_checks++; if (rf[7] !== 32'hdeadbeef) begin n_fail++; $display("FAIL starve_x7 got=%h exp=deadbeef", rf[7]); end
    endtask

    task automatic test_reset_mid();
        int c0;
        alu_valid = 1'b1; alu_rd = 5'd20; alu_data = 32'h20202020;
        mem_valid = 1'b1; mem_rd = 5'd21; mem_data = 32'h21212121;
        step();
        alu_valid = 1'b0; mem_valid = 1'b0;
        step();
        n_checks++; if (reg_write !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre_we got=%b exp=1", reg_write); end
        c0 = commits;
        reset = 1'b0;
        #1;
        n_checks++; if (reg_write !== 1'b0) begin n_fail++; $display("FAIL rstmid_reg_write got=%b exp=0", reg_write); end
        n_checks++; if (alu_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_alu_ready got=%b exp=1", alu_ready); end
        n_checks++; if (mem_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_mem_ready got=%b exp=1", mem_ready); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
        @(negedge clk);
        reset = 1'b1;
        repeat (4) step();
        n_checks++; if (commits !== c0) begin n_fail++; $display("FAIL rstmid_no_write got=%0d exp=%0d", commits, c0); end
        n_checks++; if (rf[20] !== 32'h0) begin n_fail++; $display("FAIL rstmid_x20 got=%h exp=0", rf[20]); end
        n_checks++; if (rf[21] !== 32'h0) begin n_fail++; $display("FAIL rstmid_x21 got=%h exp=0", rf[21]); end
        n_checks++; if (alu_ready !== 1'b1 || mem_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_ready_after got=%b%b exp=11", alu_ready, mem_ready); end
    endtask

    initial begin
        test_reset();
        test_alu_single();
        test_x0_filter();
        test_simultaneous();
        test_same_rd();
        test_starvation();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
